// File: rtl/bus_arbiter.sv
// Round-robin arbiter and bus driver in front of the shared data memory.
// Serialises pending messages from P0/P1/P2 onto the 16-bit bus. For misses
// it waits for memory's registered block and returns it with a one-cycle ack.
// Invalidates and no-ops are broadcast for one cycle and acked without memory.
module bus_arbiter #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_p0,
   input  logic        req_p1,
   input  logic        req_p2,
   input  logic [15:0] msg_p0,
   input  logic [15:0] msg_p1,
   input  logic [15:0] msg_p2,
   input  logic [15:0] mem_block,
   output logic [15:0] bus,
   output logic        ack_p0,
   output logic        ack_p1,
   output logic        ack_p2,
   output logic [15:0] resp_block,
   output logic [1:0]  grant,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam logic [3:0]  LATENCY  = 4'(MEM_LATENCY);
   localparam logic [15:0] BUS_IDLE = 16'hC000;
   localparam logic [1:0]  NO_GRANT = 2'b11;

   state_t      state_r, state_s;
   logic [15:0] bus_r, bus_s;
   logic [15:0] resp_r, resp_s;
   logic [2:0]  ack_r, ack_s;
   logic [1:0]  grant_r, grant_s;
   logic        busy_r, busy_s;
   logic [1:0]  last_grant_r, last_grant_s;
   logic [3:0]  cnt_r, cnt_s;
   logic        miss_r, miss_s;
   logic [2:0]  req_vec_s;
   logic [1:0]  pick_s;
   logic [15:0] sel_msg_s;
   logic [2:0]  owner_onehot_s;

   // First requester at or after last+1 (mod 3); NO_GRANT when none pending.
   function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] pick;
      pick = NO_GRANT;
      idx  = (last >= 2'd2) ? 2'd0 : last + 2'd1;
      for (int i = 0; i < 3; i++) begin
         if ((pick == NO_GRANT) && req[idx]) begin
            pick = idx;
         end
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      return pick;
   endfunction

   // Arbitration choice, selected message and owner ack vector.
   always_comb begin
      req_vec_s = {req_p2, req_p1, req_p0};
      pick_s    = rr_pick(req_vec_s, last_grant_r);
      case (pick_s)
         2'd0:    sel_msg_s = msg_p0;
         2'd1:    sel_msg_s = msg_p1;
         2'd2:    sel_msg_s = msg_p2;
         default: sel_msg_s = BUS_IDLE;
      endcase
      case (grant_r)
         2'd0:    owner_onehot_s = 3'b001;
         2'd1:    owner_onehot_s = 3'b010;
         2'd2:    owner_onehot_s = 3'b100;
         default: owner_onehot_s = 3'b000;
      endcase
   end

   // Next-state and next-output logic; ack defaults low so it pulses one cycle.
   always_comb begin
      state_s      = state_r;
      bus_s        = bus_r;
      resp_s       = resp_r;
      ack_s        = 3'b000;
      grant_s      = grant_r;
      busy_s       = busy_r;
      last_grant_s = last_grant_r;
      cnt_s        = cnt_r;
      miss_s       = miss_r;
      case (state_r)
         S_IDLE: begin
            if (pick_s != NO_GRANT) begin
               bus_s        = sel_msg_s;
               grant_s      = pick_s;
               busy_s       = 1'b1;
               last_grant_s = pick_s;
               miss_s       = ~sel_msg_s[15];
               cnt_s        = sel_msg_s[15] ? 4'd0 : LATENCY;
               state_s      = S_WAIT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_r != 4'd0) begin
               cnt_s = cnt_r - 4'd1;
            end else begin
               resp_s  = miss_r ? mem_block : 16'h0000;
               ack_s   = owner_onehot_s;
               bus_s   = BUS_IDLE;
               state_s = S_ACK;
            end
         end
         S_ACK: begin
            grant_s = NO_GRANT;
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end
         default: begin
            bus_s   = BUS_IDLE;
            grant_s = NO_GRANT;
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= S_IDLE;
         bus_r        <= BUS_IDLE;
         resp_r       <= 16'h0000;
         ack_r        <= 3'b000;
         grant_r      <= NO_GRANT;
         busy_r       <= 1'b0;
         last_grant_r <= 2'd2;
         cnt_r        <= 4'd0;
         miss_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         bus_r        <= bus_s;
         resp_r       <= resp_s;
         ack_r        <= ack_s;
         grant_r      <= grant_s;
         busy_r       <= busy_s;
         last_grant_r <= last_grant_s;
         cnt_r        <= cnt_s;
         miss_r       <= miss_s;
      end
   end

   assign bus        = bus_r;
   assign resp_block = resp_r;
   assign ack_p0     = ack_r[0];
   assign ack_p1     = ack_r[1];
   assign ack_p2     = ack_r[2];
   assign grant      = grant_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a scoreboard of expected acks/response
// blocks is filled when requests are raised and drained as acks appear.
module tb_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req_v = 3'b000;
   logic [15:0] msg_v [3];
   logic [15:0] mem_block;
   logic [15:0] bus;
   logic [2:0]  ack_v;
   logic [15:0] resp_block;
   logic [1:0]  grant;
   logic        busy;

   logic [2:0]  req3 = 3'b000;
   logic [15:0] msg3 [3];
   logic [15:0] mem3 = 16'h0000;
   logic [15:0] bus3;
   logic [2:0]  ack3;
   logic [15:0] resp3;
   logic [1:0]  grant3;
   logic        busy3;

   typedef struct packed {
      logic [15:0] bus;
      logic [1:0]  grant;
      logic        busy;
      logic [2:0]  ack;
      logic [15:0] resp;
   } sample_t;

   typedef struct {
      int          id;
      logic [15:0] resp;
   } exp_t;

   exp_t       sbq[$];
   int         checks = 0;
   int         errors = 0;
   logic [2:0] rereq   = 3'b000;
   logic [2:0] reraise = 3'b000;

   bus_arbiter dut (
      .clock(clock), .reset(reset),
      .req_p0(req_v[0]), .req_p1(req_v[1]), .req_p2(req_v[2]),
      .msg_p0(msg_v[0]), .msg_p1(msg_v[1]), .msg_p2(msg_v[2]),
      .mem_block(mem_block), .bus(bus),
      .ack_p0(ack_v[0]), .ack_p1(ack_v[1]), .ack_p2(ack_v[2]),
      .resp_block(resp_block), .grant(grant), .busy(busy)
   );

   bus_arbiter #(.MEM_LATENCY(3)) dut3 (
      .clock(clock), .reset(reset),
      .req_p0(req3[0]), .req_p1(req3[1]), .req_p2(req3[2]),
      .msg_p0(msg3[0]), .msg_p1(msg3[1]), .msg_p2(msg3[2]),
      .mem_block(mem3), .bus(bus3),
      .ack_p0(ack3[0]), .ack_p1(ack3[1]), .ack_p2(ack3[2]),
      .resp_block(resp3), .grant(grant3), .busy(busy3)
   );

   always #5 clock = ~clock;

   // Memory contents: block derived from the message tag.
   function automatic logic [15:0] mem_of(input logic [15:0] m);
      return {m[13:10], 2'b00, 6'b000000, m[13:10]};
   endfunction

   // Latency-1 registered memory for the default instance.
   always @(posedge clock) mem_block <= mem_of(bus);

   task automatic raise(input int id, input logic [15:0] m);
      exp_t e;
      msg_v[id] = m;
      req_v[id] = 1'b1;
      e.id   = id;
      e.resp = m[15] ? 16'h0000 : mem_of(m);
      sbq.push_back(e);
   endtask

   // One cycle: sample at negedge, score any ack, then run the requester handshake.
   task automatic step(output sample_t s);
      exp_t       e;
      logic [2:0] acked;
      @(negedge clock);
      s     = {bus, grant, busy, ack_v, resp_block};
      acked = ack_v;
      if (ack_v != 3'b000) begin
         checks++;
         if ($countones(ack_v) != 1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ack ack=%b pending=%0d", ack_v, sbq.size());
         end else begin
            e = sbq.pop_front();
            if (ack_v[e.id] !== 1'b1 || resp_block !== e.resp) begin
               errors++;
               $display("FAIL sb_ack got ack=%b resp=%h expected P%0d resp=%h",
                        ack_v, resp_block, e.id, e.resp);
            end
         end
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (reraise[i]) begin
            reraise[i] = 1'b0;
            raise(i, msg_v[i]);
         end
         if (acked[i]) begin
            req_v[i]   = 1'b0;
            reraise[i] = rereq[i];
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset   = 1'b0;
      req_v   = 3'b000;
      rereq   = 3'b000;
      reraise = 3'b000;
      sbq.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   function automatic int ack_id(input logic [2:0] a);
      return a[0] ? 0 : (a[1] ? 1 : 2);
   endfunction

   task automatic test_reset();
      sample_t s;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus !== 16'hC000 || ack_v !== 3'b000 || resp_block !== 16'h0000 ||
          grant !== 2'b11 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_values bus=%h ack=%b resp=%h grant=%b busy=%b expected C000/000/0000/11/0",
                  bus, ack_v, resp_block, grant, busy);
      end
      checks++;
      if (bus3 !== 16'hC000 || grant3 !== 2'b11) begin
         errors++;
         $display("FAIL reset_values_lat3 bus=%h grant=%b expected C000/11", bus3, grant3);
      end
      @(negedge clock);
      reset = 1'b1;
      step(s);
      checks++;
      if (s.grant !== 2'b11 || s.bus !== 16'hC000) begin
         errors++;
         $display("FAIL idle_no_req grant=%b bus=%h expected 11/C000", s.grant, s.bus);
      end
   endtask

   task automatic test_single_miss();
      sample_t s[8];
      int      nbus = 0;
      raise(1, 16'h2800);
      for (int k = 0; k < 8; k++) begin
         step(s[k]);
         if (s[k].bus == 16'h2800) nbus++;
      end
      checks++;
      if (nbus != 2) begin
         errors++; $display("FAIL miss_bus_cycles got %0d expected 2", nbus);
      end
      checks++;
      if (s[1].grant !== 2'd1 || s[1].busy !== 1'b1) begin
         errors++; $display("FAIL miss_grant got %b/%b expected 01/1", s[1].grant, s[1].busy);
      end
      checks++;
      if (s[2].ack !== 3'b000 || s[3].ack !== 3'b010 || s[3].resp !== 16'hA00A) begin
         errors++;
         $display("FAIL miss_ack got ack=%b,%b resp=%h expected 000,010 A00A", s[2].ack, s[3].ack, s[3].resp);
      end
      checks++;
      if (s[4].grant !== 2'b11 || s[4].busy !== 1'b0 || s[4].ack !== 3'b000 || s[4].resp !== 16'hA00A) begin
         errors++;
         $display("FAIL miss_release got grant=%b busy=%b ack=%b resp=%h expected 11/0/000/A00A",
                  s[4].grant, s[4].busy, s[4].ack, s[4].resp);
      end
   endtask

   task automatic test_invalidate();
      sample_t s[6];
      int      nbus = 0;
      int      nmiss = 0;
      raise(0, 16'h8C00);
      for (int k = 0; k < 6; k++) begin
         step(s[k]);
         if (s[k].bus == 16'h8C00) nbus++;
         if (s[k].bus[15] == 1'b0) nmiss++;
      end
      checks++;
      if (nbus != 1) begin
         errors++; $display("FAIL inv_bus_cycles got %0d expected 1", nbus);
      end
      checks++;
      if (s[1].grant !== 2'd0 || s[2].ack !== 3'b001 || s[2].resp !== 16'h0000) begin
         errors++;
         $display("FAIL inv_ack got grant=%b ack=%b resp=%h expected 00/001/0000", s[1].grant, s[2].ack, s[2].resp);
      end
      checks++;
      if (nmiss != 0) begin
         errors++; $display("FAIL inv_no_mem_miss got %0d miss cycles expected 0", nmiss);
      end
      checks++;
      if (s[3].busy !== 1'b0 || s[3].grant !== 2'b11) begin
         errors++; $display("FAIL inv_release got busy=%b grant=%b expected 0/11", s[3].busy, s[3].grant);
      end
   endtask

   task automatic test_simultaneous();
      sample_t s;
      int      order[6];
      int      n = 0;
      do_reset();
      rereq = 3'b111;
      raise(0, 16'h0400);
      raise(1, 16'h8800);
      raise(2, 16'h4C05);
      for (int c = 0; c < 80 && n < 6; c++) begin
         step(s);
         if (s.ack != 3'b000) begin
            order[n] = ack_id(s.ack);
            rereq[order[n]] = 1'b0;
            n++;
         end
      end
      checks++;
      if (n != 6) begin
         errors++; $display("FAIL simul_ack_count got %0d expected 6 (timeout)", n);
      end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (order[i] != i % 3) begin
            errors++; $display("FAIL simul_order slot %0d got P%0d expected P%0d", i, order[i], i % 3);
         end
      end
      repeat (6) step(s);
      checks++;
      if (sbq.size() != 0 || req_v !== 3'b000) begin
         errors++; $display("FAIL simul_drain got pending=%0d req=%b expected 0/000", sbq.size(), req_v);
      end
   endtask

   task automatic test_fairness();
      sample_t s;
      sample_t prev;
      int      gord[4];
      int      ng = 0;
      int      na = 0;
      rereq = 3'b101;
      raise(0, 16'hB000);
      raise(2, 16'hC123);
      prev = {16'hC000, 2'b11, 1'b0, 3'b000, 16'h0000};
      for (int c = 0; c < 80 && na < 4; c++) begin
         step(s);
         if (s.grant != 2'b11 && prev.grant == 2'b11 && ng < 4) begin
            gord[ng] = int'(s.grant);
            ng++;
            checks++;
            if (prev.bus !== 16'hC000) begin
               errors++; $display("FAIL fair_idle_gap got bus=%h before grant expected C000", prev.bus);
            end
         end
         if (s.ack != 3'b000) begin
            rereq[ack_id(s.ack)] = 1'b0;
            na++;
         end
         prev = s;
      end
      checks++;
      if (ng != 4 || na != 4) begin
         errors++; $display("FAIL fair_count got grants=%0d acks=%0d expected 4/4", ng, na);
      end
      for (int i = 0; i < ng; i++) begin
         checks++;
         if (gord[i] != ((i % 2 == 0) ? 0 : 2)) begin
            errors++; $display("FAIL fair_order slot %0d got P%0d expected P%0d", i, gord[i], (i % 2 == 0) ? 0 : 2);
         end
      end
      repeat (4) step(s);
   endtask

   task automatic test_reset_mid();
      sample_t s;
      exp_t    e;
      int      order[2];
      int      n = 0;
      raise(2, 16'h1C00);
      step(s);
      step(s);
      checks++;
      if (s.grant !== 2'd2 || s.bus !== 16'h1C00) begin
         errors++; $display("FAIL rmid_granted got grant=%b bus=%h expected 10/1C00", s.grant, s.bus);
      end
      #2 reset = 1'b0;
      sbq.delete();
      #1;
      checks++;
      if (bus !== 16'hC000 || grant !== 2'b11 || busy !== 1'b0 || ack_v !== 3'b000) begin
         errors++;
         $display("FAIL rmid_immediate got bus=%h grant=%b busy=%b ack=%b expected C000/11/0/000",
                  bus, grant, busy, ack_v);
      end
      for (int k = 0; k < 2; k++) begin
         step(s);
         checks++;
         if (s.ack !== 3'b000) begin
            errors++; $display("FAIL rmid_no_ack got ack=%b expected 000", s.ack);
         end
      end
      #2 reset = 1'b1;
      raise(0, 16'h8000);
      e.id   = 2;
      e.resp = mem_of(16'h1C00);
      sbq.push_back(e);
      for (int c = 0; c < 40 && n < 2; c++) begin
         step(s);
         if (s.ack != 3'b000) begin
            order[n] = ack_id(s.ack);
            n++;
         end
      end
      checks++;
      if (n != 2 || order[0] != 0 || order[1] != 2) begin
         errors++;
         $display("FAIL rmid_restart got n=%0d first=P%0d second=P%0d expected 2 P0 P2", n, order[0], order[1]);
      end
   endtask

   task automatic test_latency3();
      sample_t s3[8];
      int      nbus = 0;
      mem3    = 16'h7777;
      msg3[1] = 16'h4400;
      req3[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         s3[k] = {bus3, grant3, busy3, ack3, resp3};
         if (s3[k].bus == 16'h4400) nbus++;
         @(posedge clock);
         #1;
         case (k)
            1:       mem3 = 16'h1001;
            2:       mem3 = 16'h1002;
            3:       mem3 = 16'h4C33;
            4:       mem3 = 16'hFFFF;
            default: mem3 = mem3;
         endcase
         if (s3[k].ack[1]) req3[1] = 1'b0;
      end
      checks++;
      if (nbus != 4) begin
         errors++; $display("FAIL lat3_bus_cycles got %0d expected 4", nbus);
      end
      checks++;
      if (s3[4].ack !== 3'b000 || s3[5].ack !== 3'b010) begin
         errors++; $display("FAIL lat3_ack_timing got %b,%b expected 000,010", s3[4].ack, s3[5].ack);
      end
      checks++;
      if (s3[5].resp !== 16'h4C33 || s3[6].resp !== 16'h4C33) begin
         errors++; $display("FAIL lat3_resp got %h,%h expected 4C33", s3[5].resp, s3[6].resp);
      end
      checks++;
      if (s3[6].grant !== 2'b11 || s3[6].ack !== 3'b000 || s3[6].busy !== 1'b0) begin
         errors++; $display("FAIL lat3_release got grant=%b ack=%b busy=%b expected 11/000/0",
                            s3[6].grant, s3[6].ack, s3[6].busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         msg_v[i] = 16'hC000;
         msg3[i]  = 16'hC000;
      end
      test_reset();
      test_single_miss();
      test_invalidate();
      test_simultaneous();
      test_fairness();
      test_reset_mid();
      test_latency3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
